i2c_reg_bank: RTL and testbench

//  Register-file stage downstream of the I2C byte-level slave. Turns its received-byte and

---
 rtl/i2c_reg_bank_pkg.sv | 28 ++
 rtl/i2c_reg_bank_if.sv | 34 +++
 rtl/i2c_reg_bank.sv | 108 ++++++++++
 tb/tb_i2c_reg_bank.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_reg_bank_pkg.sv
// Shared types for the I2C register bank: byte type, FSM states,
// and the per-cycle event decode.
package i2c_reg_bank_pkg;

  localparam int DATA_W = 8;

  typedef logic [DATA_W-1:0] byte_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PTR,
    S_DATA
  } state_t;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_ERR,
    EV_END,
    EV_START,
    EV_RD,
    EV_WR
  } ev_t;

  function automatic byte_t sat_inc(input byte_t v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/i2c_reg_bank_if.sv
// Byte-level strobe bundle between the I2C slave (master modport)
// and the register bank (slave modport).
interface i2c_reg_bank_if;
  import i2c_reg_bank_pkg::*;

  logic  i2c_start_stb;
  logic  i2c_end_stb;
  logic  i2c_error_stb;
  byte_t i2c_data_rd;
  logic  i2c_data_rd_valid_stb;
  byte_t i2c_data_wr;
  logic  i2c_data_wr_finish_stb;

  modport master (
    output i2c_start_stb,
    output i2c_end_stb,
    output i2c_error_stb,
    output i2c_data_rd,
    output i2c_data_rd_valid_stb,
    output i2c_data_wr_finish_stb,
    input  i2c_data_wr
  );

  modport slave (
    input  i2c_start_stb,
    input  i2c_end_stb,
    input  i2c_error_stb,
    input  i2c_data_rd,
    input  i2c_data_rd_valid_stb,
    input  i2c_data_wr_finish_stb,
    output i2c_data_wr
  );

endinterface

// File: rtl/i2c_reg_bank.sv
// Pointer-addressed 8-bit register file behind the I2C byte slave:
// FSM, auto-incrementing pointer, RW flops and RO read mux.
module i2c_reg_bank
  import i2c_reg_bank_pkg::*;
#(
  parameter int                  NUM_REGS  = 16,
  parameter int                  PTR_W     = 4,
  parameter logic [NUM_REGS-1:0] RO_MASK   = '0,
  parameter byte_t               RESET_VAL = 8'h00
) (
  input  logic                    clk,
  input  logic                    rst_n,
  i2c_reg_bank_if.slave           bus,
  input  logic [NUM_REGS*8-1:0]   hw_in,
  output logic [NUM_REGS*8-1:0]   reg_q,
  output logic                    reg_wr_stb,
  output logic [PTR_W-1:0]        reg_wr_idx,
  output byte_t                   err_cnt
);

  localparam logic [8:0] NREG9 = 9'(NUM_REGS);

  state_t             state;
  logic [PTR_W-1:0]   ptr;
  logic               ptr_ok;
  byte_t              regs [NUM_REGS];
  byte_t              cur  [NUM_REGS];
  byte_t              data_wr;
  ev_t                ev;
  byte_t              rd_b;

  assign rd_b            = bus.i2c_data_rd;
  assign bus.i2c_data_wr = data_wr;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_slot
    assign cur[i] = RO_MASK[i] ? hw_in[i*8 +: 8] : regs[i];
    assign reg_q[i*8 +: 8] = cur[i];
  end

  // Several strobes can coincide; the highest-priority one wins.
  always_comb begin
    ev = EV_NONE;
    priority case (1'b1)
      bus.i2c_error_stb:          ev = EV_ERR;
      bus.i2c_end_stb:            ev = EV_END;
      bus.i2c_start_stb:          ev = EV_START;
      bus.i2c_data_rd_valid_stb:  ev = EV_RD;
      bus.i2c_data_wr_finish_stb: ev = EV_WR;
      default:                    ev = EV_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      ptr        <= '0;
      ptr_ok     <= 1'b1;
      data_wr    <= RESET_VAL;
      reg_wr_stb <= 1'b0;
      reg_wr_idx <= '0;
      err_cnt    <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= RESET_VAL;
      end
    end else begin
      reg_wr_stb <= 1'b0;
      data_wr    <= ptr_ok ? cur[ptr] : 8'hFF;
      unique case (ev)
        EV_ERR: begin
          state   <= S_IDLE;
          err_cnt <= sat_inc(err_cnt);
        end
        EV_END: begin
          state <= S_IDLE;
        end
        EV_START: begin
          state <= S_PTR;
        end
        EV_RD: begin
          unique case (state)
            S_PTR: begin
              ptr    <= rd_b[PTR_W-1:0];
              ptr_ok <= {1'b0, rd_b} < NREG9;
              state  <= S_DATA;
            end
            S_DATA: begin
              if (ptr_ok && !RO_MASK[ptr]) begin
                regs[ptr]  <= rd_b;
                reg_wr_stb <= 1'b1;
                reg_wr_idx <= ptr;
              end
              ptr <= ptr + 1'b1;
            end
            default: ;
          endcase
        end
        EV_WR: begin
          if (state != S_IDLE) begin
            ptr   <= ptr + 1'b1;
            state <= S_DATA;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Randomized scoreboard bench for i2c_reg_bank with a
// transaction-level register model.
module tb_i2c_reg_bank;

  localparam int         N   = 16;
  localparam logic [15:0] RO = 16'h0001;
  localparam logic [7:0]  RV = 8'h00;

  typedef struct {
    logic [3:0] idx;
    logic [7:0] d;
  } wexp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N*8-1:0] hw_in = '0;
  logic [N*8-1:0] reg_q;
  logic           reg_wr_stb;
  logic [3:0]     reg_wr_idx;
  logic [7:0]     err_cnt;

  i2c_reg_bank_if bus ();

  i2c_reg_bank #(
    .NUM_REGS (N),
    .PTR_W    (4),
    .RO_MASK  (RO),
    .RESET_VAL(RV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .hw_in     (hw_in),
    .reg_q     (reg_q),
    .reg_wr_stb(reg_wr_stb),
    .reg_wr_idx(reg_wr_idx),
    .err_cnt   (err_cnt)
  );

  always #50 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] m_regs [N];
  int         m_ptr;
  bit         m_ok;
  bit         m_active;
  bit         m_have_ptr;
  int         m_err;
  wexp_t      wq[$];
  logic [7:0] rq[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] m_read();
    if (!m_ok) return 8'hFF;
    if (RO[m_ptr]) return hw_in[m_ptr*8 +: 8];
    return m_regs[m_ptr];
  endfunction

  function automatic logic [7:0] m_slot(input int i);
    return RO[i] ? hw_in[i*8 +: 8] : m_regs[i];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) m_regs[i] = RV;
    m_ptr = 0;
    m_ok = 1'b1;
    m_active = 1'b0;
    m_have_ptr = 1'b0;
    m_err = 0;
  endtask

  task automatic m_byte(input logic [7:0] d);
    if (!m_active) return;
    if (!m_have_ptr) begin
      m_ptr = d % N;
      m_ok = d < N;
      m_have_ptr = 1'b1;
    end else begin
      if (m_ok && !RO[m_ptr]) begin
        m_regs[m_ptr] = d;
        wq.push_back('{idx: 4'(m_ptr), d: d});
      end
      m_ptr = (m_ptr + 1) % N;
    end
  endtask

  task automatic m_load();
    rq.push_back(m_read());
    m_ptr = (m_ptr + 1) % N;
    m_have_ptr = 1'b1;
  endtask

  task automatic clr();
    bus.i2c_start_stb = 1'b0;
    bus.i2c_end_stb = 1'b0;
    bus.i2c_error_stb = 1'b0;
    bus.i2c_data_rd_valid_stb = 1'b0;
    bus.i2c_data_wr_finish_stb = 1'b0;
  endtask

  // k: 0 start, 1 end, 2 error, 3 byte received, 4 byte loaded, 5 error+byte
  task automatic pulse(input int k, input logic [7:0] d);
    @(negedge clk);
    bus.i2c_data_rd = d;
    case (k)
      0: begin
        bus.i2c_start_stb = 1'b1;
        m_active = 1'b1;
        m_have_ptr = 1'b0;
      end
      1: begin
        bus.i2c_end_stb = 1'b1;
        m_active = 1'b0;
      end
      2, 5: begin
        bus.i2c_error_stb = 1'b1;
        if (k == 5) bus.i2c_data_rd_valid_stb = 1'b1;
        m_active = 1'b0;
        if (m_err < 255) m_err++;
      end
      3: begin
        bus.i2c_data_rd_valid_stb = 1'b1;
        m_byte(d);
      end
      default: begin
        bus.i2c_data_wr_finish_stb = 1'b1;
        m_load();
      end
    endcase
    @(negedge clk);
    clr();
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_wr_stb", reg_wr_stb, 0);
    chk("rst_data_wr", bus.i2c_data_wr, RV);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic cmp_all(input string nm);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s_reg%0d", nm, i), reg_q[i*8 +: 8], m_slot(i));
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (reg_wr_stb) begin
      if (wq.size() == 0) begin
        chk("unexpected_wr_stb", 1, 0);
      end else begin
        wexp_t e;
        e = wq.pop_front();
        chk("wr_idx", reg_wr_idx, e.idx);
        chk("wr_data", reg_q[reg_wr_idx*8 +: 8], e.d);
      end
    end
    if (bus.i2c_data_wr_finish_stb) begin
      if (rq.size() == 0) begin
        chk("unexpected_load", 1, 0);
      end else begin
        logic [7:0] r;
        r = rq.pop_front();
        chk("data_wr", bus.i2c_data_wr, r);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    bus.i2c_data_rd = '0;
    m_reset();
    hw_in = '0;
    do_reset();
    cmp_all("reset");

    // pointer then two data bytes
    pulse(0, 0); pulse(3, 8'h03); pulse(3, 8'hA5); pulse(3, 8'h5A); pulse(1, 0);
    chk("t1_reg3", reg_q[3*8 +: 8], 8'hA5);
    chk("t1_reg4", reg_q[4*8 +: 8], 8'h5A);

    // wrap from 15 to 0 on reads, repeated start keeps pointer
    hw_in[7:0] = 8'hC3;
    pulse(0, 0); pulse(3, 8'h0F); pulse(0, 0);
    pulse(4, 0); pulse(4, 0); pulse(4, 0); pulse(1, 0);

    // write to RO reg dropped, read returns hw_in
    pulse(0, 0); pulse(3, 8'h00); pulse(3, 8'h11);
    pulse(0, 0); pulse(3, 8'h00); pulse(4, 0); pulse(1, 0);
    chk("t3_ro_slot", reg_q[7:0], 8'hC3);

    // out-of-range pointer
    pulse(0, 0); pulse(3, 8'h40); pulse(3, 8'h12); pulse(4, 0); pulse(4, 0); pulse(1, 0);
    cmp_all("t4");

    // error collides with data byte
    pulse(0, 0); pulse(3, 8'h05); pulse(3, 8'h77); pulse(5, 8'h99);
    pulse(3, 8'h55);
    chk("t5_err1", err_cnt, 1);
    chk("t5_reg6", reg_q[6*8 +: 8], 8'h00);
    for (int i = 0; i < 256; i++) pulse(2, 0);
    chk("t5_err_sat", err_cnt, 8'hFF);
    cmp_all("t5");

    // reset between data bytes
    pulse(0, 0); pulse(3, 8'h02); pulse(3, 8'hAA);
    do_reset();
    cmp_all("t6_rst");
    pulse(0, 0); pulse(3, 8'h07); pulse(3, 8'h33); pulse(4, 0); pulse(1, 0);
    chk("t6_reg7", reg_q[7*8 +: 8], 8'h33);
    chk("t6_err", err_cnt, 0);

    // random transactions
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        hw_in = {$urandom, $urandom, $urandom, $urandom};
      end
      if ($urandom_range(0, 5) == 0) pulse(3, 8'($urandom));
      pulse(0, 0);
      if ($urandom_range(0, 4) != 0) pulse(3, 8'($urandom_range(0, 23)));
      for (int j = 0; j < $urandom_range(1, 6); j++) begin
        if ($urandom_range(0, 1) == 0) pulse(3, 8'($urandom));
        else pulse(4, 0);
        if ($urandom_range(0, 9) == 0) pulse(0, 0);
      end
      if ($urandom_range(0, 9) == 0) pulse(2, 0);
      else pulse(1, 0);
    end
    cmp_all("rand");
    chk("rand_err", err_cnt, m_err);
    repeat (3) @(negedge clk);
    chk("wq_drained", wq.size(), 0);
    chk("rq_drained", rq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
